// File: rtl/ace_snoop_collector.sv
// ace_snoop_collector: broadcasts one snoop on AC to a masked set of masters,
// merges their CR responses and forwards one CD line from the lowest-indexed
// responder with DataTransfer set. All other data-carrying responders are drained.
//
// Handshakes: a transfer happens on a channel in the cycle where its valid and
// ready are both high. Once this block raises a valid, it holds the valid and its
// payload until the transfer. CD forwarding is a combinational pass-through, so
// the selected master's valid/ready and data go straight to and from the out_cd port.
module ace_snoop_collector #(
   parameter int unsigned NumMst          = 4,
   parameter int unsigned AddrWidth       = 64,
   parameter int unsigned DataWidth       = 64,
   parameter int unsigned DcacheLineWidth = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [AddrWidth-1:0]        req_addr_i,
   input  logic [3:0]                  req_snoop_i,
   input  logic [NumMst-1:0]           req_mask_i,
   output logic [NumMst-1:0]           ac_valid_o,
   input  logic [NumMst-1:0]           ac_ready_i,
   output logic [AddrWidth-1:0]        ac_addr_o,
   output logic [3:0]                  ac_snoop_o,
   input  logic [NumMst-1:0]           cr_valid_i,
   output logic [NumMst-1:0]           cr_ready_o,
   input  logic [5*NumMst-1:0]         cr_resp_i,
   input  logic [NumMst-1:0]           cd_valid_i,
   output logic [NumMst-1:0]           cd_ready_o,
   input  logic [DataWidth*NumMst-1:0] cd_data_i,
   input  logic [NumMst-1:0]           cd_last_i,
   output logic                        out_cr_valid_o,
   input  logic                        out_cr_ready_i,
   output logic [4:0]                  out_cr_resp_o,
   output logic                        out_cd_valid_o,
   input  logic                        out_cd_ready_i,
   output logic [DataWidth-1:0]        out_cd_data_o,
   output logic                        out_cd_last_o,
   output logic                        proto_err_o
);

   localparam int unsigned CdBeats = DcacheLineWidth / DataWidth;
   localparam int unsigned CntW    = (CdBeats > 1) ? $clog2(CdBeats) : 1;
   localparam int unsigned SelW    = (NumMst > 1) ? $clog2(NumMst) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CdBeats - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNOOP = 2'd1,
      RESP  = 2'd2,
      DATA  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [3:0]            snoop_q, snoop_d;
   logic [NumMst-1:0]     mask_q, mask_d;
   logic [NumMst-1:0]     ac_done_q, ac_done_d;
   logic [NumMst-1:0]     cr_done_q, cr_done_d;
   logic [4:0]            resp_q, resp_d;
   logic [NumMst-1:0]     dt_mask_q, dt_mask_d;
   logic [SelW-1:0]       sel_q, sel_d;
   logic [NumMst-1:0]     cd_done_q, cd_done_d;
   logic [CntW-1:0]       cnt_q [NumMst];
   logic [CntW-1:0]       cnt_d [NumMst];
   logic                  proto_err_q, proto_err_d;

   // The AC payload is the registered request, so it cannot move mid-snoop.
   assign ac_addr_o   = addr_q;
   assign ac_snoop_o  = snoop_q;
   assign proto_err_o = proto_err_q;

   // Next-state, register updates and all channel outputs for the current state.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      snoop_d        = snoop_q;
      mask_d         = mask_q;
      ac_done_d      = ac_done_q;
      cr_done_d      = cr_done_q;
      resp_d         = resp_q;
      dt_mask_d      = dt_mask_q;
      sel_d          = sel_q;
      cd_done_d      = cd_done_q;
      cnt_d          = cnt_q;
      proto_err_d    = 1'b0;
      req_ready_o    = 1'b0;
      ac_valid_o     = '0;
      cr_ready_o     = '0;
      cd_ready_o     = '0;
      out_cr_valid_o = 1'b0;
      out_cr_resp_o  = resp_q;
      out_cd_valid_o = 1'b0;
      out_cd_data_o  = '0;
      out_cd_last_o  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Held low while reset is applied so no request slips in.
            req_ready_o = ~rst_i;
            if (req_valid_i) begin
               addr_d    = req_addr_i;
               snoop_d   = req_snoop_i;
               mask_d    = req_mask_i;
               ac_done_d = '0;
               cr_done_d = '0;
               resp_d    = '0;
               dt_mask_d = '0;
               sel_d     = '0;
               cd_done_d = '0;
               for (int i = 0; i < int'(NumMst); i++) cnt_d[i] = '0;
               // An empty mask has nobody to ask: answer with a zero response.
               state_d   = (req_mask_i == '0) ? RESP : SNOOP;
            end
         end

         SNOOP: begin
            ac_valid_o = mask_q & ~ac_done_q;
            // Registered ac_done keeps CR acceptance strictly after its AC.
            cr_ready_o = ac_done_q & ~cr_done_q;
            ac_done_d  = ac_done_q | (ac_valid_o & ac_ready_i);
            for (int i = 0; i < int'(NumMst); i++) begin
               if (cr_ready_o[i] && cr_valid_i[i]) begin
                  cr_done_d[i] = 1'b1;
                  resp_d       = resp_d | cr_resp_i[5*i +: 5];
                  dt_mask_d[i] = cr_resp_i[5*i];
               end
            end
            if (cr_done_d == mask_q) begin
               state_d = RESP;
               // Lowest-indexed data responder supplies the forwarded line.
               sel_d   = '0;
               for (int i = int'(NumMst) - 1; i >= 0; i--) begin
                  if (dt_mask_d[i]) sel_d = SelW'(i);
               end
            end
         end

         RESP: begin
            out_cr_valid_o = 1'b1;
            if (out_cr_ready_i) state_d = (dt_mask_q != '0) ? DATA : IDLE;
         end

         DATA: begin
            for (int j = 0; j < int'(NumMst); j++) begin
               if (dt_mask_q[j] && !cd_done_q[j]) begin
                  if (sel_q == SelW'(j)) begin
                     cd_ready_o[j]  = out_cd_ready_i;
                     out_cd_valid_o = cd_valid_i[j];
                     out_cd_data_o  = cd_data_i[DataWidth*j +: DataWidth];
                     out_cd_last_o  = (cnt_q[j] == LastCnt);
                  end else begin
                     cd_ready_o[j] = 1'b1;
                  end
                  if (cd_ready_o[j] && cd_valid_i[j]) begin
                     // The beat count is authoritative; a wrong last only flags.
                     if (cd_last_i[j] != (cnt_q[j] == LastCnt)) proto_err_d = 1'b1;
                     if (cnt_q[j] == LastCnt) begin
                        cnt_d[j]     = '0;
                        cd_done_d[j] = 1'b1;
                     end else begin
                        cnt_d[j] = cnt_q[j] + CntW'(1);
                     end
                  end
               end
            end
            if ((cd_done_d & dt_mask_q) == dt_mask_q) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and transaction registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         snoop_q     <= '0;
         mask_q      <= '0;
         ac_done_q   <= '0;
         cr_done_q   <= '0;
         resp_q      <= '0;
         dt_mask_q   <= '0;
         sel_q       <= '0;
         cd_done_q   <= '0;
         cnt_q       <= '{default: '0};
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         snoop_q     <= snoop_d;
         mask_q      <= mask_d;
         ac_done_q   <= ac_done_d;
         cr_done_q   <= cr_done_d;
         resp_q      <= resp_d;
         dt_mask_q   <= dt_mask_d;
         sel_q       <= sel_d;
         cd_done_q   <= cd_done_d;
         cnt_q       <= cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_ace_snoop_collector.sv
// tb_ace_snoop_collector: table of directed snoop transactions plus random ones,
// with behavioural snooped masters and an expectation model derived from the
// response-merge, responder-selection and line-length rules.
module tb_ace_snoop_collector;

   localparam int N     = 4;
   localparam int AW    = 64;
   localparam int DW    = 64;
   localparam int LW    = 256;
   localparam int BEATS = LW / DW;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            req_valid_i;
   logic            req_ready_o;
   logic [AW-1:0]   req_addr_i;
   logic [3:0]      req_snoop_i;
   logic [N-1:0]    req_mask_i;
   logic [N-1:0]    ac_valid_o;
   logic [N-1:0]    ac_ready_i;
   logic [AW-1:0]   ac_addr_o;
   logic [3:0]      ac_snoop_o;
   logic [N-1:0]    cr_valid_i;
   logic [N-1:0]    cr_ready_o;
   logic [5*N-1:0]  cr_resp_i;
   logic [N-1:0]    cd_valid_i;
   logic [N-1:0]    cd_ready_o;
   logic [DW*N-1:0] cd_data_i;
   logic [N-1:0]    cd_last_i;
   logic            out_cr_valid_o;
   logic            out_cr_ready_i;
   logic [4:0]      out_cr_resp_o;
   logic            out_cd_valid_o;
   logic            out_cd_ready_i;
   logic [DW-1:0]   out_cd_data_o;
   logic            out_cd_last_o;
   logic            proto_err_o;

   // Clock
   always #5 clk = ~clk;

   ace_snoop_collector #(
      .NumMst(N), .AddrWidth(AW), .DataWidth(DW), .DcacheLineWidth(LW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_snoop_i(req_snoop_i), .req_mask_i(req_mask_i),
      .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
      .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o),
      .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
      .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o),
      .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
      .out_cr_valid_o(out_cr_valid_o), .out_cr_ready_i(out_cr_ready_i),
      .out_cr_resp_o(out_cr_resp_o),
      .out_cd_valid_o(out_cd_valid_o), .out_cd_ready_i(out_cd_ready_i),
      .out_cd_data_o(out_cd_data_o), .out_cd_last_o(out_cd_last_o),
      .proto_err_o(proto_err_o)
   );

   typedef struct {
      logic [N-1:0]   mask;
      logic [5*N-1:0] resp;      // CRRESP of master i at [5i +: 5]
      logic [4*N-1:0] ac_dly;    // cycle from which master i raises ac_ready
      logic [N-1:0]   cr_early;  // master raises cr_valid before its AC
      int             cr_dly;    // cycles out_cr_ready lags out_cr_valid
      bit             full;      // no CD stalls on either side
      int             bad_mst;   // master that flips cd_last on one beat (-1 none)
      int             bad_beat;
      int             rst_beat;  // reset after this many forwarded beats (0 none)
      logic [4:0]     exp_resp;
      logic [N-1:0]   exp_dt;
      int             exp_sel;
      int             exp_cr_cyc; // -1: not checked
      int             exp_cd_cyc; // -1: not checked
      int             exp_err;
   } vec_t;

   int tests  = 0;
   int fails  = 0;
   int cur_id = 0;

   // Scoreboard compare
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL t%0d %s: got %0h expected %0h", cur_id, nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(input int id, input int m, input int b);
      return {16'hCD5A, 16'(id), 16'(m), 16'(b)};
   endfunction

   function automatic vec_t mk(input logic [N-1:0] mask, input logic [5*N-1:0] resp,
                               input logic [4*N-1:0] ac_dly, input logic [N-1:0] cr_early,
                               input int cr_dly, input bit full, input int bad_mst,
                               input int bad_beat, input int rst_beat,
                               input logic [4:0] exp_resp, input logic [N-1:0] exp_dt,
                               input int exp_sel, input int exp_cr_cyc,
                               input int exp_cd_cyc, input int exp_err);
      vec_t v;
      v.mask = mask; v.resp = resp; v.ac_dly = ac_dly; v.cr_early = cr_early;
      v.cr_dly = cr_dly; v.full = full; v.bad_mst = bad_mst; v.bad_beat = bad_beat;
      v.rst_beat = rst_beat; v.exp_resp = exp_resp; v.exp_dt = exp_dt;
      v.exp_sel = exp_sel; v.exp_cr_cyc = exp_cr_cyc; v.exp_cd_cyc = exp_cd_cyc;
      v.exp_err = exp_err;
      return v;
   endfunction

   // Reference model: merged response is the OR over snooped masters, data
   // responders are snooped masters with DataTransfer, the lowest one forwards.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_resp = '0;
      r.exp_dt   = '0;
      r.exp_sel  = 0;
      for (int i = 0; i < N; i++) begin
         if (v.mask[i]) begin
            r.exp_resp = r.exp_resp | v.resp[5*i +: 5];
            r.exp_dt[i] = v.resp[5*i];
         end
      end
      for (int i = N - 1; i >= 0; i--) if (r.exp_dt[i]) r.exp_sel = i;
      r.exp_err = (v.bad_beat >= 0 && v.bad_mst >= 0 && r.exp_dt[v.bad_mst]) ? 1 : 0;
      r.exp_cr_cyc = -1;
      r.exp_cd_cyc = -1;
      return r;
   endfunction

   // Driver: all inputs quiet
   task automatic idle_inputs();
      req_valid_i = 0; req_addr_i = '0; req_snoop_i = '0; req_mask_i = '0;
      ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
      cd_valid_i = '0; cd_data_i = '0; cd_last_i = '0;
      out_cr_ready_i = 0; out_cd_ready_i = 0;
   endtask

   task automatic reset_checks(input string nm);
      check({nm, " ac_valid"}, 64'(ac_valid_o), 64'd0);
      check({nm, " cr_ready"}, 64'(cr_ready_o), 64'd0);
      check({nm, " cd_ready"}, 64'(cd_ready_o), 64'd0);
      check({nm, " out_cr_valid"}, 64'(out_cr_valid_o), 64'd0);
      check({nm, " out_cd_valid"}, 64'(out_cd_valid_o), 64'd0);
      check({nm, " proto_err"}, 64'(proto_err_o), 64'd0);
   endtask

   // Driver + monitor for one snoop transaction (request handshake is cycle 0)
   task automatic run_txn(input vec_t v, input int id);
      logic [N-1:0]  got_ac, cr_sent, cd_v;
      int            beat [N];
      int            fwd, err_seen, cr_first, cd_first, cr_wait;
      bit            cr_hs, finished, aborted;
      logic [AW-1:0] addr;
      logic [3:0]    snp;
      cur_id = id;
      got_ac = '0; cr_sent = '0; cd_v = '0;
      for (int i = 0; i < N; i++) beat[i] = 0;
      fwd = 0; err_seen = 0; cr_first = -1; cd_first = -1; cr_wait = 0;
      cr_hs = 0; finished = 0; aborted = 0;
      addr = {$urandom, $urandom};
      snp  = 4'($urandom_range(0, 15));

      @(negedge clk);
      idle_inputs();
      req_valid_i = 1; req_addr_i = addr; req_snoop_i = snp; req_mask_i = v.mask;
      #1 check("req_ready", 64'(req_ready_o), 64'd1);

      for (int c = 1; c < 300 && !finished; c++) begin
         @(negedge clk);
         req_valid_i = 0; req_addr_i = {$urandom, $urandom}; req_mask_i = N'($urandom);
         for (int i = 0; i < N; i++) begin
            if (v.mask[i]) begin
               ac_ready_i[i] = (c >= int'(v.ac_dly[4*i +: 4]));
               cr_valid_i[i] = (v.cr_early[i] | got_ac[i]) & ~cr_sent[i];
               cr_resp_i[5*i +: 5] = v.resp[5*i +: 5];
            end else begin
               ac_ready_i[i] = 1'($urandom_range(0, 1));
               cr_valid_i[i] = 1'($urandom_range(0, 1));
               cr_resp_i[5*i +: 5] = 5'($urandom);
            end
            if (!cd_v[i])
               cd_v[i] = v.mask[i] && cr_sent[i] && v.resp[5*i] && beat[i] < BEATS &&
                         (v.full || $urandom_range(0, 2) != 0);
            cd_valid_i[i] = cd_v[i];
            cd_data_i[DW*i +: DW] = word(id, i, beat[i]);
            cd_last_i[i] = (beat[i] == BEATS - 1) ^ (i == v.bad_mst && beat[i] == v.bad_beat);
         end
         out_cr_ready_i = (cr_wait >= v.cr_dly);
         out_cd_ready_i = v.full ? 1'b1 : ($urandom_range(0, 3) != 0);
         #1;
         for (int i = 0; i < N; i++) begin
            if (ac_valid_o[i]) begin
               check("ac_valid_legal", 64'(v.mask[i] & ~got_ac[i]), 64'd1);
               check("ac_addr", ac_addr_o, addr);
               check("ac_snoop", 64'(ac_snoop_o), 64'(snp));
            end
            if (cr_ready_o[i]) check("cr_after_ac", 64'(got_ac[i] & ~cr_sent[i]), 64'd1);
            if (cd_ready_o[i]) check("cd_ready_dt", 64'(v.exp_dt[i]), 64'd1);
         end
         if (out_cr_valid_o) begin
            check("out_cr_resp", 64'(out_cr_resp_o), 64'(v.exp_resp));
            if (cr_first < 0) begin
               cr_first = c;
               check("all_cr_in", 64'(cr_sent), 64'(v.mask));
               if (v.exp_cr_cyc >= 0) check("cr_latency", 64'(c), 64'(v.exp_cr_cyc));
            end
            if (out_cr_ready_i) cr_hs = 1;
            cr_wait++;
         end
         if (out_cd_valid_o && out_cd_ready_i) begin
            if (cd_first < 0) begin
               cd_first = c;
               if (v.exp_cd_cyc >= 0) check("cd_latency", 64'(c), 64'(v.exp_cd_cyc));
            end
            check("cd_data", out_cd_data_o, word(id, v.exp_sel, fwd));
            check("cd_last", 64'(out_cd_last_o), 64'(fwd == BEATS - 1));
            check("cd_src", 64'(cd_valid_i[v.exp_sel] & cd_ready_o[v.exp_sel]), 64'd1);
            fwd++;
         end
         if (proto_err_o) err_seen++;
         if (req_ready_o && cr_hs) finished = 1;
         for (int i = 0; i < N; i++) begin
            if (ac_valid_o[i] & ac_ready_i[i]) got_ac[i] = 1;
            if (cr_valid_i[i] & cr_ready_o[i]) cr_sent[i] = 1;
            if (cd_valid_i[i] & cd_ready_o[i]) begin
               beat[i]++;
               cd_v[i] = 0;
            end
         end
         if (v.rst_beat > 0 && fwd == v.rst_beat) begin
            @(negedge clk);
            rst_i = 1;
            idle_inputs();
            @(posedge clk);
            #1 reset_checks("mid_rst");
            check("mid_rst req_ready", 64'(req_ready_o), 64'd0);
            @(negedge clk);
            rst_i = 0;
            @(posedge clk);
            #1 check("post_rst req_ready", 64'(req_ready_o), 64'd1);
            reset_checks("post_rst");
            aborted = 1;
            finished = 1;
         end
      end

      check("done_in_budget", 64'(finished), 64'd1);
      if (!aborted) begin
         check("ac_handshakes", 64'(got_ac), 64'(v.mask));
         check("cr_handshakes", 64'(cr_sent), 64'(v.mask));
         check("fwd_beats", 64'(fwd), 64'(v.exp_dt != '0 ? BEATS : 0));
         for (int i = 0; i < N; i++)
            check($sformatf("m%0d_cd_beats", i), 64'(beat[i]), 64'(v.exp_dt[i] ? BEATS : 0));
         check("proto_err_pulses", 64'(err_seen), 64'(v.exp_err));
      end
   endtask

   initial begin
      vec_t tbl [9];
      vec_t rv;
      rst_i = 1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 reset_checks("reset");
      check("reset req_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk);
      rst_i = 0;
      @(posedge clk);
      #1 check("req_ready after reset", 64'(req_ready_o), 64'd1);

      //            mask     resp      ac_dly   early   crd full bm  bb rst  exp_resp  dt      sel cr  cd err
      tbl[0] = mk(4'b0000, 20'h00000, 16'h0000, 4'b0000, 0, 1, -1, -1, 0, 5'b00000, 4'b0000, 0, 1, -1, 0);
      tbl[1] = mk(4'b1010, 20'h40100, 16'h0000, 4'b0000, 0, 1, -1, -1, 0, 5'b01000, 4'b0000, 0, 3, -1, 0);
      tbl[2] = mk(4'b1111, 20'h280A0, 16'h0000, 4'b0000, 0, 1, -1, -1, 0, 5'b00101, 4'b1010, 1, 3,  4, 0);
      tbl[3] = mk(4'b0101, 20'h02010, 16'h0005, 4'b0100, 0, 1, -1, -1, 0, 5'b11000, 4'b0000, 0, 7, -1, 0);
      tbl[4] = mk(4'b0001, 20'h00001, 16'h0000, 4'b0000, 0, 1,  0,  1, 0, 5'b00001, 4'b0001, 0, 3,  4, 1);
      tbl[5] = mk(4'b0011, 20'h00021, 16'h0000, 4'b0000, 0, 1, -1, -1, 1, 5'b00001, 4'b0011, 0, 3,  4, 0);
      tbl[6] = mk(4'b0011, 20'h00021, 16'h0000, 4'b0000, 0, 1, -1, -1, 0, 5'b00001, 4'b0011, 0, 3,  4, 0);
      tbl[7] = mk(4'b1000, 20'hB8000, 16'h0000, 4'b0000, 3, 0, -1, -1, 0, 5'b10111, 4'b1000, 3, 3, -1, 0);
      tbl[8] = mk(4'b0110, 20'h00C20, 16'h0000, 4'b0000, 0, 0,  2,  3, 0, 5'b00011, 4'b0110, 1, 3, -1, 1);

      for (int t = 0; t < 9; t++) run_txn(tbl[t], t);

      for (int t = 0; t < 40; t++) begin
         rv = mk(N'($urandom), 20'($urandom), '0, N'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, N - 1),
                 $urandom_range(0, BEATS + 1) - 2, 0, '0, '0, 0, -1, -1, 0);
         for (int i = 0; i < N; i++) rv.ac_dly[4*i +: 4] = 4'($urandom_range(0, 6));
         run_txn(model(rv), 100 + t);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
